// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Framing errors hold off re-arming until the line returns high.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data_byte,
    output logic       o_data_valid,
    output logic       o_active,
    output logic       o_frame_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [7:0]       r_data_byte;
    logic             r_data_valid;
    logic             r_active;
    logic             r_frame_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_data_byte  <= 8'h00;
            r_data_valid <= 1'b0;
            r_active     <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    if (!r_rx_s) begin
                        r_state  <= StStart;
                        r_active <= 1'b1;
                    end else begin
                        r_active <= 1'b0;
                    end
                end
                StStart: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= StData;
                        end else begin
                            // Start bit did not hold to mid-bit: treat as a glitch.
                            r_state  <= StIdle;
                            r_active <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= StStop;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_data_byte  <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= StIdle;
                            r_active     <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= StWaitHigh;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state  <= StIdle;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_byte  = r_data_byte;
    assign o_data_valid = r_data_valid;
    assign o_active     = r_active;
    assign o_frame_err  = r_frame_err;

endmodule
